// File: rtl/soc_event_tx.sv
// FC event FIFO producer: per-source saturating pending counters, round-robin arbiter, output queue.
// Define SOC_EVENT_TX_DROP_CNT_EN to add the dropped-event counter (drop_clr_i / drop_cnt_o).
module soc_event_tx #(
  parameter int unsigned NB_SRC         = 8,
  parameter int unsigned EVENT_ID_WIDTH = 8,
  parameter int unsigned ID_BASE        = 0,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned SrcW          = (NB_SRC > 1) ? $clog2(NB_SRC) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_SRC-1:0]         src_evt_i,
  output logic                      event_fifo_valid_o,
  input  logic                      event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
`ifdef SOC_EVENT_TX_DROP_CNT_EN
  input  logic                      drop_clr_i,
  output logic [15:0]               drop_cnt_o,
`endif
  output logic                      overflow_o,
  output logic [SrcW-1:0]           overflow_src_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  if ((longint'(ID_BASE) + longint'(NB_SRC) - 1) >= (longint'(1) << EVENT_ID_WIDTH)) begin : g_bad_id
    $error("soc_event_tx: ID_BASE+NB_SRC-1 does not fit in EVENT_ID_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("soc_event_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [CNT_WIDTH-1:0]      cnt_q [NB_SRC];
  logic [CNT_WIDTH-1:0]      cnt_d [NB_SRC];
  logic [SrcW-1:0]           rr_q, rr_d;
  logic [NB_SRC-1:0]         drop;
  logic                      cand_vld, gnt_vld;
  logic [SrcW-1:0]           gnt_idx;
  int unsigned               arb_idx;
  logic                      ovf_q, ovf_d;
  logic [SrcW-1:0]           ovf_src_q, ovf_src_d;

  logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [EVENT_ID_WIDTH-1:0] last_q;
  logic [AW:0]               wr_q, rd_q;
  logic                      empty, full, pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && event_fifo_fulln_i;

  assign event_fifo_valid_o = !empty;
  // When empty, present the last popped ID rather than whatever stale slot rd_q points at.
  assign event_fifo_data_o  = empty ? last_q : mem_q[rd_q[AW-1:0]];
  assign overflow_o         = ovf_q;
  assign overflow_src_o     = ovf_src_q;

  always_comb begin
    cand_vld = 1'b0;
    gnt_idx  = '0;
    arb_idx  = 0;
    for (int k = 0; k < int'(NB_SRC); k++) begin
      arb_idx = (int'(rr_q) + k) % NB_SRC;
      if (!cand_vld && (cnt_q[SrcW'(arb_idx)] != '0)) begin
        cand_vld = 1'b1;
        gnt_idx  = SrcW'(arb_idx);
      end
    end
    // A full queue can still take a push when the head leaves on the same edge.
    gnt_vld = cand_vld && (!full || pop);
    rr_d    = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_idx == SrcW'(NB_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NB_SRC); i++) begin
      logic g;
      g        = gnt_vld && (gnt_idx == SrcW'(i));
      drop[i]  = src_evt_i[i] && !g && (cnt_q[i] == CntMax);
      cnt_d[i] = cnt_q[i];
      if (src_evt_i[i] && !g && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!src_evt_i[i] && g) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    ovf_d     = |drop;
    ovf_src_d = ovf_src_q;
    for (int i = int'(NB_SRC) - 1; i >= 0; i--) begin
      if (drop[i]) ovf_src_d = SrcW'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NB_SRC); i++) cnt_q[i] <= '0;
      rr_q      <= '0;
      ovf_q     <= 1'b0;
      ovf_src_q <= '0;
    end else begin
      for (int i = 0; i < int'(NB_SRC); i++) cnt_q[i] <= cnt_d[i];
      rr_q      <= rr_d;
      ovf_q     <= ovf_d;
      ovf_src_q <= ovf_src_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      if (gnt_vld) begin
        mem_q[wr_q[AW-1:0]] <= EVENT_ID_WIDTH'(ID_BASE + int'(gnt_idx));
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) begin
        last_q <= mem_q[rd_q[AW-1:0]];
        rd_q   <= rd_q + 1'b1;
      end
    end
  end

`ifdef SOC_EVENT_TX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  int unsigned ndrop;

  always_comb begin
    ndrop = 0;
    for (int i = 0; i < int'(NB_SRC); i++) ndrop += {31'd0, drop[i]};
    drop_cnt_d = ((int'(drop_cnt_q) + ndrop) > 32'd65535) ? 16'hFFFF
                                                           : 16'(int'(drop_cnt_q) + ndrop);
    if (drop_clr_i) drop_cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
